manch_enc_gen: RTL

Parametrised Manchester transmitter, successor to the fixed 8-bit `manch_en` encoder. It buffers words in a small FIFO and frames each one with a 3-bit-time sync pattern and an optional odd-parity bit. It encodes in run-time-selectable IEEE 802.3 or G.E. Thomas convention and runs at OVS clocks per bit. It sits between a byte/word source and the line driver, and sends queued words back-to-back with no idle gap.

---
 rtl/manch_enc_gen.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/manch_enc_gen.sv
// manch_enc_gen: buffered Manchester transmitter.
// Words are queued in a DEPTH-deep FIFO. Each word is sent as a frame:
// a 3-bit-time sync (high 1.5 bits, low 1.5 bits), DW data bits MSB first,
// and an optional odd-parity bit. Every bit lasts OVS clocks and is made of
// two half-bits. Queued frames go out back-to-back with no idle gap.
//
// Ports:
//   clk16x  oversampling clock, rising edge
//   rstn    asynchronous reset, active-high (1 = reset)
//   wr      write strobe; din is queued when wr=1 and full=0
//   din     data word
//   conv    0 = IEEE (~b then b), 1 = G.E. Thomas (b then ~b); sampled at pop
//   par_en  1 = append odd parity after the data; sampled at pop
//   full    FIFO holds DEPTH words (registered)
//   tbre    FIFO empty (registered)
//   busy    a frame is being sent (registered)
//   ovf     one-cycle pulse after a write was dropped because full was set
//   mdo     Manchester serial output (registered)
module manch_enc_gen #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int OVS   = 16
) (
  input  logic          clk16x,
  input  logic          rstn,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          conv,
  input  logic          par_en,
  output logic          full,
  output logic          tbre,
  output logic          busy,
  output logic          ovf,
  output logic          mdo
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = $clog2(OVS);
  // The sync phase reuses the bit counter to count 3 bit times, so it needs
  // at least two bits even for very narrow words.
  localparam int BW   = ($clog2(DW + 1) < 2) ? 2 : $clog2(DW + 1);
  localparam int HALF = OVS / 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_PAR
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_d;
  logic          full_q, full_d, tbre_q, tbre_d, ovf_q, ovf_d;
  logic          push, pop, empty;
  logic [DW-1:0] head;

  // Acceptance looks at the registered full flag, so a write in a full cycle
  // is dropped even if the FSM pops in that same cycle.
  assign push  = wr && !full_q;
  assign empty = (wptr_q == rptr_q);
  assign head  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d  = wptr_q + {{AW{1'b0}}, push};
    rptr_d  = rptr_q + {{AW{1'b0}}, pop};
    count_d = wptr_d - rptr_d;
    full_d  = (count_d == (AW + 1)'(DEPTH));
    tbre_d  = (wptr_d == rptr_d);
    ovf_d   = wr && full_q;
  end

  // NOTE: storage array has no reset; the pointers alone define which
  // entries are valid, and resetting the array would only cost logic.
  always_ff @(posedge clk16x) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= din;
  end

  // ------------------------------------------------------------------ FSM
  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [BW-1:0] bitc_q, bitc_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic          par_bit_q, par_bit_d;
  logic          conv_f_q, conv_f_d;
  logic          par_en_f_q, par_en_f_d;
  logic          mdo_q, mdo_d, busy_q, busy_d;
  logic          last_phase, first_half, level, do_load, frame_end;

  assign last_phase = (phase_q == PW'(OVS - 1));
  assign first_half = (phase_q < PW'(HALF));

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bitc_d     = bitc_q;
    shreg_d    = shreg_q;
    par_bit_d  = par_bit_q;
    conv_f_d   = conv_f_q;
    par_en_f_d = par_en_f_q;
    level      = 1'b0;
    do_load    = 1'b0;
    frame_end  = 1'b0;

    if (state_q != S_IDLE) phase_d = last_phase ? '0 : phase_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        do_load = !empty;
      end
      S_SYNC: begin
        // High for bit time 0 and the first half of bit time 1, low after.
        level = (bitc_q == '0) || ((bitc_q == BW'(1)) && first_half);
        if (last_phase) begin
          if (bitc_q == BW'(2)) begin
            bitc_d  = '0;
            state_d = S_DATA;
          end else begin
            bitc_d = bitc_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        // First half sends b ^ ~conv, second half b ^ conv.
        level = shreg_q[DW-1] ^ conv_f_q ^ first_half;
        if (last_phase) begin
          shreg_d = shreg_q << 1;
          if (bitc_q == BW'(DW - 1)) begin
            bitc_d = '0;
            if (par_en_f_q) state_d = S_PAR;
            else            frame_end = 1'b1;
          end else begin
            bitc_d = bitc_q + 1'b1;
          end
        end
      end
      S_PAR: begin
        level = par_bit_q ^ conv_f_q ^ first_half;
        if (last_phase) frame_end = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Last clock of a frame: chain straight into the next queued word.
    if (frame_end) begin
      if (!empty) do_load = 1'b1;
      else        state_d = S_IDLE;
    end

    if (do_load) begin
      state_d    = S_SYNC;
      phase_d    = '0;
      bitc_d     = '0;
      shreg_d    = head;
      par_bit_d  = ~^head;
      conv_f_d   = conv;
      par_en_f_d = par_en;
    end

    pop    = do_load;
    mdo_d  = level;
    busy_d = (state_q != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of order.
  always_ff @(posedge clk16x or posedge rstn) begin
    if (rstn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      full_q     <= 1'b0;
      tbre_q     <= 1'b1;
      ovf_q      <= 1'b0;
      state_q    <= S_IDLE;
      phase_q    <= '0;
      bitc_q     <= '0;
      shreg_q    <= '0;
      par_bit_q  <= 1'b0;
      conv_f_q   <= 1'b0;
      par_en_f_q <= 1'b0;
      mdo_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      full_q     <= full_d;
      tbre_q     <= tbre_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      phase_q    <= phase_d;
      bitc_q     <= bitc_d;
      shreg_q    <= shreg_d;
      par_bit_q  <= par_bit_d;
      conv_f_q   <= conv_f_d;
      par_en_f_q <= par_en_f_d;
      mdo_q      <= mdo_d;
      busy_q     <= busy_d;
    end
  end

  assign full = full_q;
  assign tbre = tbre_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign mdo  = mdo_q;

endmodule
